// File: rtl/sort4_ctrl.sv
// sort4_ctrl: four-element 4-bit bubble sorter, one adjacent compare per cycle with early exit
module sort4_ctrl #(
   parameter bit ASCENDING = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] din,
   output logic        busy,
   output logic        done,
   output logic [15:0] dout,
   output logic [2:0]  swap_cnt
);
   typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
   state_t state;
   logic [3:0][3:0] r, rs;
   logic [1:0] pass, idx, nidx;
   logic [3:0] a, b;
   logic swapped, do_swap, last, finish;
   // compare the current pair and form the working registers after an optional swap
   always_comb begin
      nidx = idx + 2'd1;
      a = r[idx];
      b = r[nidx];
      do_swap = ASCENDING ? (a > b) : (a < b);
      last = idx == 2'd2 - pass;
      finish = last && (!(swapped || do_swap) || pass == 2'd2);
      rs = r;
      rs[idx] = do_swap ? b : a;
      rs[nidx] = do_swap ? a : b;
   end
   // control FSM with registered outputs; rst overrides everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         r <= '0;
         pass <= '0;
         idx <= '0;
         swapped <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         dout <= '0;
         swap_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  r <= din;
                  swap_cnt <= '0;
                  pass <= '0;
                  idx <= '0;
                  swapped <= 1'b0;
                  busy <= 1'b1;
                  state <= CMP;
               end
            end
            CMP: begin
               r <= rs;
               swap_cnt <= swap_cnt + {2'b00, do_swap};
               if (finish) begin
                  dout <= rs;
                  done <= 1'b1;
                  state <= DONE;
               end else if (last) begin
                  pass <= pass + 2'd1;
                  idx <= '0;
                  swapped <= 1'b0;
               end else begin
                  idx <= nidx;
                  swapped <= swapped | do_swap;
               end
            end
            DONE: begin
               done <= 1'b0;
               busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sort4_ctrl.sv
// tb_sort4_ctrl: scoreboard bench running an ascending and a descending sorter side by side
module tb_sort4_ctrl;
   typedef struct {
      logic [15:0] d;
      logic [15:0] o;
      int sw;
      int n;
      int t0;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic [15:0] din = '0;
   logic busy_w [2];
   logic done_w [2];
   logic [15:0] dout_w [2];
   logic [2:0] swc_w [2];
   logic rst_q = 1'b1;
   logic [15:0] last_d [2];
   int last_s [2];
   int cyc = 0;
   int tests = 0;
   int fails = 0;
   exp_t q0[$];
   exp_t q1[$];

   sort4_ctrl #(.ASCENDING(1'b1)) dut_asc (
      .clk(clk), .rst(rst), .start(start), .din(din),
      .busy(busy_w[0]), .done(done_w[0]), .dout(dout_w[0]), .swap_cnt(swc_w[0])
   );
   sort4_ctrl #(.ASCENDING(1'b0)) dut_dsc (
      .clk(clk), .rst(rst), .start(start), .din(din),
      .busy(busy_w[1]), .done(done_w[1]), .dout(dout_w[1]), .swap_cnt(swc_w[1])
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      rst_q <= rst;
   end

   // reference: sorted result by value ordering, swaps = strict inversions, compares via pass counting
   function automatic void model(input logic [15:0] d, input bit asc, output logic [15:0] o,
                                 output int sw, output int n);
      int e[4];
      int s[$];
      int a[4];
      int t;
      bit any;
      for (int i = 0; i < 4; i++) e[i] = int'(d[4*i +: 4]);
      for (int v = 0; v < 16; v++)
         for (int i = 0; i < 4; i++)
            if (e[i] == (asc ? v : 15 - v)) s.push_back(e[i]);
      o = '0;
      for (int i = 0; i < 4; i++) o[4*i +: 4] = 4'(s[i]);
      sw = 0;
      for (int i = 0; i < 4; i++)
         for (int j = i + 1; j < 4; j++)
            if (asc ? e[i] > e[j] : e[i] < e[j]) sw++;
      a = e;
      n = 0;
      for (int p = 0; p < 3; p++) begin
         any = 1'b0;
         for (int i = 0; i <= 2 - p; i++) begin
            n++;
            if (asc ? a[i] > a[i+1] : a[i] < a[i+1]) begin
               t = a[i]; a[i] = a[i+1]; a[i+1] = t;
               any = 1'b1;
            end
         end
         if (!any) break;
      end
   endfunction

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // monitor: pop on each done pulse, otherwise confirm results are held while idle
   always @(negedge clk) begin
      exp_t e;
      bit empty;
      for (int k = 0; k < 2; k++) begin
         if (rst_q) begin
            last_d[k] = '0;
            last_s[k] = 0;
         end else if (done_w[k]) begin
            empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
               check($sformatf("unexpected_done[%0d]", k), 1, 0);
            end else begin
               e = (k == 0) ? q0.pop_front() : q1.pop_front();
               check($sformatf("dout[%0d] din=%h", k, e.d), int'(dout_w[k]), int'(e.o));
               check($sformatf("swap_cnt[%0d] din=%h", k, e.d), int'(swc_w[k]), e.sw);
               check($sformatf("latency[%0d] din=%h", k, e.d), cyc + 1 - e.t0, e.n + 1);
               last_d[k] = e.o;
               last_s[k] = e.sw;
            end
         end else if (!busy_w[k]) begin
            check($sformatf("hold_dout[%0d]", k), int'(dout_w[k]), int'(last_d[k]));
            check($sformatf("hold_swap[%0d]", k), int'(swc_w[k]), last_s[k]);
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while ((busy_w[0] || busy_w[1]) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (busy_w[0] || busy_w[1]) check("idle_timeout", 1, 0);
   endtask

   task automatic sort_one(input logic [15:0] d, input bit poke);
      exp_t e;
      wait_idle();
      din = d;
      start = 1'b1;
      e.d = d;
      e.t0 = cyc + 1;
      model(d, 1'b1, e.o, e.sw, e.n);
      q0.push_back(e);
      model(d, 1'b0, e.o, e.sw, e.n);
      q1.push_back(e);
      @(negedge clk);
      start = 1'b0;
      din = 16'($urandom);
      if (poke) begin
         @(negedge clk);
         start = 1'b1;
         din = 16'($urandom);
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   initial begin
      logic [15:0] dir [5];
      dir[0] = 16'h0213;
      dir[1] = 16'h3210;
      dir[2] = 16'hAAAA;
      dir[3] = 16'h05AF;
      dir[4] = 16'h0123;
      start = 1'b1;
      din = 16'hFFFF;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst_busy[%0d]", k), int'(busy_w[k]), 0);
         check($sformatf("rst_done[%0d]", k), int'(done_w[k]), 0);
         check($sformatf("rst_dout[%0d]", k), int'(dout_w[k]), 0);
         check($sformatf("rst_swap[%0d]", k), int'(swc_w[k]), 0);
      end
      start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) check($sformatf("post_rst_idle[%0d]", k), int'(busy_w[k]), 0);
      foreach (dir[i]) sort_one(dir[i], 1'b0);
      for (int i = 0; i < 40; i++) sort_one(16'($urandom), ($urandom_range(0, 2) == 0));
      wait_idle();
      din = 16'h0213;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      din = 16'h3210;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("abort_busy[%0d]", k), int'(busy_w[k]), 0);
         check($sformatf("abort_done[%0d]", k), int'(done_w[k]), 0);
         check($sformatf("abort_dout[%0d]", k), int'(dout_w[k]), 0);
         check($sformatf("abort_swap[%0d]", k), int'(swc_w[k]), 0);
      end
      repeat (10) @(negedge clk);
      sort_one(16'h05AF, 1'b0);
      sort_one(16'h1C7E, 1'b1);
      wait_idle();
      repeat (3) @(negedge clk);
      check("pending_asc", q0.size(), 0);
      check("pending_dsc", q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sort4_ctrl.md
SORT4_CTRL -- requirements
Module: sort4_ctrl

Interface
REQ-001 SHALL have parameter: ASCENDING, 1, 1 = sort ascending (element 0 smallest), 0 = sort descending.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to sort din; sampled only in IDLE.
REQ-005 SHALL have port: din  input  16  four unsigned 4-bit elements, e0=din[3:0], e1=din[7:4], e2=din[11:8], e3=din[15:12].
REQ-006 SHALL have port: busy  output  1  high in CMP and DONE states.
REQ-007 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-008 SHALL have port: dout  output  16  sorted elements, same lane packing as din.
REQ-009 SHALL have port: swap_cnt  output  3  number of swaps performed for the last sort (0..6).

Function
REQ-010 SHALL implement the FSM states IDLE, CMP and DONE.
REQ-011 SHALL, in IDLE with start=1, latch din into four working registers, clear swap_cnt, set pass=0 and idx=0, and go to CMP.
REQ-012 SHALL compare exactly one adjacent pair (r[idx], r[idx+1]) per CMP cycle, using unsigned 4-bit greater/less/equal magnitude comparison.
REQ-013 SHALL swap the pair in that cycle when ASCENDING=1 and r[idx]>r[idx+1], or when ASCENDING=0 and r[idx]<r[idx+1].
REQ-014 SHALL never swap equal elements, so the sort is stable.
REQ-015 SHALL increment swap_cnt by 1 on each swap and set the per-pass swapped flag.
REQ-016 SHALL scan idx over 0..(2-pass) in each pass; pass 0 = 3 compares, pass 1 = 2 compares, pass 2 = 1 compare.
REQ-017 SHALL, at the last compare of a pass, go to DONE if no swap occurred in that pass (including a swap on this compare) or if pass=2.
REQ-018 SHALL otherwise, at the last compare of a pass, increment pass, reset idx to 0, clear the swapped flag, and stay in CMP.
REQ-019 SHALL, on the transition into DONE, load dout from the working registers (reflecting any final swap).
REQ-020 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-021 SHALL hold dout and swap_cnt from DONE until the next accepted start.
REQ-022 Latency: start sampled at edge T0, N compare cycles -> done high in cycle T0+N+1.
REQ-023 SHALL use N=3 for already-sorted input and N=6 worst case; 3 <= N <= 6 always.
REQ-024 SHALL ignore start while busy=1; the in-progress sort is not disturbed and no restart is queued.
REQ-025 SHALL ignore din outside the start-accept cycle.
REQ-026 SHALL accept start in the IDLE cycle immediately following DONE, giving back-to-back sorts with one IDLE cycle between them.

Reset
REQ-027 SHALL, with rst=1 at a clock edge, force state=IDLE, busy=0, done=0, dout=16'h0000, swap_cnt=0, and clear the working registers, pass, idx and swapped flag.
REQ-028 SHALL give rst priority over start.
REQ-029 SHALL abort a sort on rst asserted mid-operation with no done pulse, leaving all outputs at reset values.
REQ-030 SHALL remain in IDLE in the first cycle after rst deasserts until start is sampled.

Verification
REQ-031 ASCENDING=1, din=16'h0213 (e=3,1,2,0) -> dout=16'h3210, swap_cnt=5, done at T0+7.
REQ-032 ASCENDING=1, din=16'h3210 (already sorted) -> dout=16'h3210, swap_cnt=0, done at T0+4, early exit after pass 0.
REQ-033 ASCENDING=1, din=16'hAAAA (all equal) -> dout=16'hAAAA, swap_cnt=0, done at T0+4.
REQ-034 ASCENDING=1, din=16'h05AF (e=F,A,5,0, reversed) -> dout=16'hFA50, swap_cnt=6, done at T0+7.
REQ-035 ASCENDING=0, din=16'h3210 -> dout=16'h0123, swap_cnt=6, done at T0+7.
REQ-036 Start with din=16'h0213, pulse start with din=16'h3210 at T0+3, assert rst at T0+5 for one cycle -> second start ignored, no done pulse, dout=0, swap_cnt=0, busy=0 at T0+6; a new start then sorts normally.
